// File: rtl/irq_conditioner_if.sv
// ============================================================================
// irq_conditioner_if: button/mask/counter bundle for irq_conditioner. Rev 1.0
// ============================================================================
`default_nettype none

interface irq_conditioner_if #(
  parameter int N_IRQ = 3,
  parameter int CNT_W = 8
);
  logic [N_IRQ-1:0]       btn_in;
  logic [N_IRQ-1:0]       mask;
  logic                   clr_cnt;
  logic [N_IRQ-1:0]       ir_out;
  logic [N_IRQ-1:0]       busy;
  logic [N_IRQ*CNT_W-1:0] cnt_out;

  modport master (
    output btn_in, mask, clr_cnt,
    input  ir_out, busy, cnt_out
  );

  modport slave (
    input  btn_in, mask, clr_cnt,
    output ir_out, busy, cnt_out
  );
endinterface

`default_nettype wire

// File: rtl/irq_conditioner.sv
// ============================================================================
// irq_conditioner: sync, debounce, mask and fixed-width pulse per IRQ line. Rev 1.0
// ============================================================================
`default_nettype none

module irq_conditioner #(
  parameter int N_IRQ     = 3,
  parameter int DEBOUNCE  = 500000,
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  irq_conditioner_if.slave bus
);

  localparam int DC_W = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
  localparam int PC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DEBOUNCE - 1);
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  generate
    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
      logic             s1;
      logic             s2;
      state_t           state;
      logic [DC_W-1:0]  dc;
      logic             busy_r;
      logic             ir;
      logic [PC_W-1:0]  pc;
      logic [CNT_W-1:0] cnt;
      logic             fire;
      logic             start;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
        end else begin
          s1 <= bus.btn_in[i];
          s2 <= s1;
        end
      end

      assign fire  = (state == S_RISE) && s2 && (dc == DC_LAST);
      // A fire during an active pulse is dropped entirely, including the count.
      assign start = fire && bus.mask[i] && !ir;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state  <= S_LOW;
          dc     <= '0;
          busy_r <= 1'b0;
        end else begin
          case (state)
            S_LOW: begin
              if (s2) begin
                state  <= S_RISE;
                dc     <= '0;
                busy_r <= 1'b1;
              end
            end
            S_RISE: begin
              if (!s2) begin
                state  <= S_LOW;
                busy_r <= 1'b0;
              end else if (dc == DC_LAST) begin
                state <= S_HIGH;
              end else begin
                dc <= dc + DC_W'(1);
              end
            end
            S_HIGH: begin
              if (!s2) begin
                state <= S_FALL;
                dc    <= '0;
              end
            end
            S_FALL: begin
              if (s2) begin
                state <= S_HIGH;
              end else if (dc == DC_LAST) begin
                state  <= S_LOW;
                busy_r <= 1'b0;
              end else begin
                dc <= dc + DC_W'(1);
              end
            end
            default: begin
              state  <= S_LOW;
              busy_r <= 1'b0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ir <= 1'b0;
          pc <= '0;
        end else if (ir) begin
          if (pc == PC_LAST) begin
            ir <= 1'b0;
          end else begin
            pc <= pc + PC_W'(1);
          end
        end else if (start) begin
          ir <= 1'b1;
          pc <= '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (bus.clr_cnt) begin
          cnt <= '0;
        end else if (start && (cnt != CNT_MAX)) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign bus.ir_out[i]                  = ir;
      assign bus.busy[i]                    = busy_r;
      assign bus.cnt_out[i*CNT_W +: CNT_W]  = cnt;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_irq_conditioner.sv
// ============================================================================
// tb_irq_conditioner: directed scenario bench for irq_conditioner. Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_conditioner;

  localparam int N_IRQ     = 3;
  localparam int DEBOUNCE  = 4;
  localparam int PULSE_LEN = 4;
  localparam int CNT_W     = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  irq_conditioner_if #(.N_IRQ(N_IRQ), .CNT_W(CNT_W)) bus ();

  irq_conditioner #(
    .N_IRQ(N_IRQ), .DEBOUNCE(DEBOUNCE), .PULSE_LEN(PULSE_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.btn_in  = '0;
    bus.mask    = 3'b111;
    bus.clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.btn_in = 3'b111;
    #1;
    tests++;
    if ({bus.ir_out, bus.busy, bus.cnt_out} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ir=%b busy=%b cnt=%h, want all zero",
               bus.ir_out, bus.busy, bus.cnt_out);
    end
    apply_reset();
    @(posedge clk); #1;
    tests++;
    if ({bus.ir_out, bus.busy, bus.cnt_out} !== '0) begin
      fails++;
      $display("FAIL reset_release: got ir=%b busy=%b cnt=%h, want all zero",
               bus.ir_out, bus.busy, bus.cnt_out);
    end
  endtask

  task automatic test_clean_press();
    logic exp;
    apply_reset();
    bus.btn_in = 3'b001;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      exp = (k >= 6) && (k <= 9);
      tests++;
      if (bus.ir_out !== {2'b00, exp}) begin
        fails++;
        $display("FAIL clean_ir edge %0d: got %b, want %b", k, bus.ir_out, {2'b00, exp});
      end
      if (k == 1 || k == 2) begin
        tests++;
        if (bus.busy[0] !== (k == 2)) begin
          fails++;
          $display("FAIL clean_busy edge %0d: got %b, want %b", k, bus.busy[0], k == 2);
        end
      end
    end
    bus.btn_in = '0;
    repeat (10) @(negedge clk);
    tests++;
    if (bus.cnt_out !== 24'h000001) begin
      fails++;
      $display("FAIL clean_cnt: got %h, want 000001", bus.cnt_out);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      bus.btn_in = {1'b0, (k % 2 == 0), 1'b0};
      @(posedge clk); #1;
      tests++;
      if (bus.ir_out[1] !== 1'b0) begin
        fails++;
        $display("FAIL bounce_ir cycle %0d: got %b, want 0", k, bus.ir_out[1]);
      end
      @(negedge clk);
    end
    bus.btn_in = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.busy[1] !== 1'b0 || bus.ir_out[1] !== 1'b0) begin
      fails++;
      $display("FAIL bounce_idle: got busy=%b ir=%b, want 0 0", bus.busy[1], bus.ir_out[1]);
    end
    tests++;
    if (bus.cnt_out !== 24'h000000) begin
      fails++;
      $display("FAIL bounce_cnt: got %h, want 000000", bus.cnt_out);
    end
  endtask

  task automatic test_release_bounce();
    logic [0:29] pat;
    int          rises;
    int          highs;
    logic        prev;
    pat   = {12'hFFF, 4'b0101, 14'b0};
    rises = 0;
    highs = 0;
    prev  = 1'b0;
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      bus.btn_in = {pat[k], 2'b00};
      @(posedge clk); #1;
      if (bus.ir_out[2] && !prev) rises++;
      if (bus.ir_out[2]) highs++;
      prev = bus.ir_out[2];
      @(negedge clk);
    end
    tests++;
    if (rises !== 1 || highs !== PULSE_LEN) begin
      fails++;
      $display("FAIL relbounce_pulse: got rises=%0d highs=%0d, want 1 and %0d",
               rises, highs, PULSE_LEN);
    end
    tests++;
    if (bus.cnt_out !== 24'h010000) begin
      fails++;
      $display("FAIL relbounce_cnt: got %h, want 010000", bus.cnt_out);
    end
  endtask

  task automatic test_mask_simultaneous();
    int highs;
    highs = 0;
    apply_reset();
    bus.mask   = 3'b101;
    bus.btn_in = 3'b111;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (bus.ir_out[0]) highs++;
      tests++;
      if (bus.ir_out[1] !== 1'b0 || bus.ir_out[0] !== bus.ir_out[2]) begin
        fails++;
        $display("FAIL mask_sim edge %0d: got ir=%b, want ir1=0 and ir0==ir2", k, bus.ir_out);
      end
      // Dropping the mask mid-pulse must not cut the pulse short.
      if (k == 7) bus.mask = 3'b000;
    end
    tests++;
    if (highs !== PULSE_LEN) begin
      fails++;
      $display("FAIL mask_width: got %0d, want %0d", highs, PULSE_LEN);
    end
    bus.btn_in = '0;
    repeat (10) @(negedge clk);
    tests++;
    if (bus.cnt_out !== 24'h010001) begin
      fails++;
      $display("FAIL mask_cnt: got %h, want 010001", bus.cnt_out);
    end
  endtask

  task automatic press_line0();
    @(negedge clk);
    bus.btn_in = 3'b001;
    repeat (10) @(negedge clk);
    bus.btn_in = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_saturation_clear();
    apply_reset();
    for (int p = 0; p < 255; p++) press_line0();
    tests++;
    if (bus.cnt_out[7:0] !== 8'd255) begin
      fails++;
      $display("FAIL sat_255: got %0d, want 255", bus.cnt_out[7:0]);
    end
    for (int p = 0; p < 5; p++) press_line0();
    tests++;
    if (bus.cnt_out[7:0] !== 8'd255) begin
      fails++;
      $display("FAIL sat_260: got %0d, want 255", bus.cnt_out[7:0]);
    end
    @(negedge clk);
    bus.btn_in = 3'b001;
    repeat (6) @(negedge clk);
    bus.clr_cnt = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.cnt_out[7:0] !== 8'd0 || bus.ir_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL clr_on_fire: got cnt=%0d ir0=%b, want 0 1", bus.cnt_out[7:0], bus.ir_out[0]);
    end
    @(negedge clk);
    bus.clr_cnt = 1'b0;
    repeat (10) @(negedge clk);
    bus.btn_in = 3'b000;
    repeat (10) @(negedge clk);
    press_line0();
    tests++;
    if (bus.cnt_out[7:0] !== 8'd1) begin
      fails++;
      $display("FAIL cnt_after_clr: got %0d, want 1", bus.cnt_out[7:0]);
    end
  endtask

  task automatic test_async_reset();
    logic exp;
    apply_reset();
    bus.btn_in = 3'b001;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (bus.ir_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre: got ir0=%b, want 1", bus.ir_out[0]);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.ir_out !== 3'b000 || bus.busy !== 3'b000 || bus.cnt_out !== 24'h0) begin
      fails++;
      $display("FAIL areset_drop: got ir=%b busy=%b cnt=%h, want zeros",
               bus.ir_out, bus.busy, bus.cnt_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      exp = (k >= 6) && (k <= 9);
      tests++;
      if (bus.ir_out[0] !== exp) begin
        fails++;
        $display("FAIL areset_repress edge %0d: got %b, want %b", k, bus.ir_out[0], exp);
      end
    end
    bus.btn_in = '0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    bus.btn_in  = '0;
    bus.mask    = 3'b111;
    bus.clr_cnt = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_mask_simultaneous();
    test_saturation_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
